// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with hazard detect and optional perf counters.
// Optional counters enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_reg #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [31:0]      alu_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [3:0]       ctrl_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    output logic             valid_o,
    output logic [31:0]      alu_data_o,
    output logic [31:0]      rs2_data_o,
    output logic [4:0]       rd_addr_o,
    output logic [3:0]       ctrl_o,
    output logic             hazard_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic [3:0] ctrl_cap;
    logic       rd_nz;

    // Bubbles carry no control; x0 is never a write target.
    assign rd_nz    = (rd_addr_i != 5'd0);
    assign ctrl_cap = valid_i ? {ctrl_i[3] & rd_nz, ctrl_i[2:0]} : 4'b0000;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            alu_data_o <= 32'd0;
            rs2_data_o <= 32'd0;
            rd_addr_o  <= 5'd0;
            ctrl_o     <= 4'b0000;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            alu_data_o <= 32'd0;
            rs2_data_o <= 32'd0;
            rd_addr_o  <= 5'd0;
            ctrl_o     <= 4'b0000;
        end else if (!stall_i) begin
            valid_o    <= valid_i;
            alu_data_o <= alu_data_i;
            rs2_data_o <= rs2_data_i;
            rd_addr_o  <= rd_addr_i;
            ctrl_o     <= ctrl_cap;
        end
    end

    assign hazard_o = valid_o & ctrl_o[3] & (rd_addr_o != 5'd0) &
                      ((rd_addr_o == id_rs1_addr_i) |
                       (rd_addr_o == id_rs2_addr_i));

`ifdef EX_MEM_PERF_CNT_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = stall_i & ~flush_i;
    assign bubble_evt = flush_i | (~stall_i & ~valid_i);

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_evt && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (bubble_evt && (bubble_cnt_o != '1))
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg (CNT_W=4).
module tb_ex_mem_reg;

`ifdef EX_MEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i, flush_i, valid_i;
    logic [31:0] alu_data_i, rs2_data_i;
    logic [4:0]  rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
    logic [3:0]  ctrl_i;
    logic        valid_o, hazard_o;
    logic [31:0] alu_data_o, rs2_data_o;
    logic [4:0]  rd_addr_o;
    logic [3:0]  ctrl_o;
    logic [3:0]  stall_cnt_o, bubble_cnt_o;

    int errors = 0;
    int checks = 0;

    ex_mem_reg #(.CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .alu_data_i(alu_data_i), .rs2_data_i(rs2_data_i),
        .rd_addr_i(rd_addr_i), .ctrl_i(ctrl_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .valid_o(valid_o), .alu_data_o(alu_data_o),
        .rs2_data_o(rs2_data_o), .rd_addr_o(rd_addr_o),
        .ctrl_o(ctrl_o), .hazard_o(hazard_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(valid_o), 32'd0);
        chk({tag, ".alu"}, alu_data_o, 32'd0);
        chk({tag, ".rs2"}, rs2_data_o, 32'd0);
        chk({tag, ".rd"}, 32'(rd_addr_o), 32'd0);
        chk({tag, ".ctrl"}, 32'(ctrl_o), 32'd0);
        chk({tag, ".haz"}, 32'(hazard_o), 32'd0);
        chk({tag, ".scnt"}, 32'(stall_cnt_o), 32'd0);
        chk({tag, ".bcnt"}, 32'(bubble_cnt_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        alu_data_i = 32'd0; rs2_data_i = 32'd0;
        rd_addr_i = 5'd0; ctrl_i = 4'd0;
        id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        #12;
        chk_zero("rst");

        // Capture
        valid_i = 1'b1; alu_data_i = 32'hF800_0000;
        rs2_data_i = 32'h1234_5678; rd_addr_i = 5'd5; ctrl_i = 4'b1001;
        id_rs1_addr_i = 5'd5;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("cap.valid", 32'(valid_o), 32'd1);
        chk("cap.alu", alu_data_o, 32'hF800_0000);
        chk("cap.rs2", rs2_data_o, 32'h1234_5678);
        chk("cap.rd", 32'(rd_addr_o), 32'd5);
        chk("cap.ctrl", 32'(ctrl_o), 32'h9);
        chk("cap.haz_rs1", 32'(hazard_o), 32'd1);
        id_rs1_addr_i = 5'd4;
        #1;
        chk("cap.haz_none", 32'(hazard_o), 32'd0);

        // Stall 3 cycles with changing inputs
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_data_i = 32'hA000_0000 + 32'(i);
            rs2_data_i = 32'hB000_0000 + 32'(i);
            rd_addr_i = 5'(10 + i);
            ctrl_i = 4'b0110;
            valid_i = i[0];
            tick();
            chk("stall.alu", alu_data_o, 32'hF800_0000);
            chk("stall.rd", 32'(rd_addr_o), 32'd5);
        end
        chk("stall.valid", 32'(valid_o), 32'd1);
        chk("stall.ctrl", 32'(ctrl_o), 32'h9);
        chk("stall.rs2", rs2_data_o, 32'h1234_5678);
        chk("stall.scnt", 32'(stall_cnt_o), ev(3));
        chk("stall.bcnt", 32'(bubble_cnt_o), ev(0));

        // Flush wins over stall
        valid_i = 1'b1; flush_i = 1'b1; stall_i = 1'b1;
        rd_addr_i = 5'd12; ctrl_i = 4'b1111;
        tick();
        chk("flush.valid", 32'(valid_o), 32'd0);
        chk("flush.ctrl", 32'(ctrl_o), 32'd0);
        chk("flush.rd", 32'(rd_addr_o), 32'd0);
        chk("flush.alu", alu_data_o, 32'd0);
        chk("flush.bcnt", 32'(bubble_cnt_o), ev(1));
        chk("flush.scnt", 32'(stall_cnt_o), ev(3));

        // Bubble capture forces ctrl to zero
        flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
        rd_addr_i = 5'd9; ctrl_i = 4'b1111;
        tick();
        chk("bub.valid", 32'(valid_o), 32'd0);
        chk("bub.ctrl", 32'(ctrl_o), 32'd0);
        chk("bub.rd", 32'(rd_addr_o), 32'd9);
        chk("bub.bcnt", 32'(bubble_cnt_o), ev(2));

        // Hazard on rs2
        valid_i = 1'b1; rd_addr_i = 5'd7; ctrl_i = 4'b1000;
        id_rs1_addr_i = 5'd3; id_rs2_addr_i = 5'd7;
        tick();
        chk("haz.ctrl", 32'(ctrl_o), 32'h8);
        chk("haz.rs2", 32'(hazard_o), 32'd1);

        // x0 destination: rd_wren dropped
        rd_addr_i = 5'd0; ctrl_i = 4'b1000; id_rs2_addr_i = 5'd0;
        tick();
        chk("x0.ctrl", 32'(ctrl_o), 32'd0);
        chk("x0.haz", 32'(hazard_o), 32'd0);
        ctrl_i = 4'b1110;
        tick();
        chk("x0.ctrl2", 32'(ctrl_o), 32'h6);
        chk("x0.bcnt", 32'(bubble_cnt_o), ev(2));

        // Asynchronous reset mid-cycle
        rd_addr_i = 5'd3; ctrl_i = 4'b1000; id_rs1_addr_i = 5'd3;
        tick();
        chk("pre.valid", 32'(valid_o), 32'd1);
        chk("pre.haz", 32'(hazard_o), 32'd1);
        stall_i = 1'b1; flush_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        chk_zero("arst");
        #1 rst_ni = 1'b1;

        // First post-reset edge is a normal capture
        stall_i = 1'b0; flush_i = 1'b0;
        rd_addr_i = 5'd6; ctrl_i = 4'b1000;
        alu_data_i = 32'h0000_0042;
        tick();
        chk("post.valid", 32'(valid_o), 32'd1);
        chk("post.rd", 32'(rd_addr_o), 32'd6);
        chk("post.alu", alu_data_o, 32'h0000_0042);
        chk("post.bcnt", 32'(bubble_cnt_o), 32'd0);

        // Saturation
        stall_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat.scnt", 32'(stall_cnt_o), ev(15));
        chk("sat.bcnt", 32'(bubble_cnt_o), 32'd0);
        chk("sat.rd", 32'(rd_addr_o), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter CNT_W, default 32, width of performance counters.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 stall_i  input  1  hold current contents (MEM stage not accepting).
REQ-005 flush_i  input  1  replace next capture with a bubble.
REQ-006 valid_i  input  1  EX stage holds a real instruction.
REQ-007 alu_data_i  input  32  EX result (shifter/adder/logic output).
REQ-008 rs2_data_i  input  32  store data.
REQ-009 rd_addr_i  input  5  destination register.
REQ-010 ctrl_i  input  4  {rd_wren, mem_wren, wb_sel[1:0]}.
REQ-011 id_rs1_addr_i  input  5  ID-stage source 1 for hazard check.
REQ-012 id_rs2_addr_i  input  5  ID-stage source 2 for hazard check.
REQ-013 valid_o  output  1  registered valid.
REQ-014 alu_data_o  output  32  registered EX result.
REQ-015 rs2_data_o  output  32  registered store data.
REQ-016 rd_addr_o  output  5  registered destination.
REQ-017 ctrl_o  output  4  registered control bundle.
REQ-018 hazard_o  output  1  RAW hazard against ID stage (combinational from registered state).
REQ-019 stall_cnt_o  output  CNT_W  cycles with stall_i asserted.
REQ-020 bubble_cnt_o  output  CNT_W  bubbles inserted.

Function
REQ-021 Latency: exactly one cycle; inputs sampled on the edge appear on outputs after that edge.
REQ-022 Normal (stall_i=0, flush_i=0): capture all inputs; valid_o <= valid_i.
REQ-023 Stall (stall_i=1, flush_i=0): all registered outputs hold unchanged.
REQ-024 Flush (flush_i=1): valid_o <= 0, ctrl_o <= 4'b0000, rd_addr_o <= 0; data fields don't-care but SHALL be driven 0.
REQ-025 flush_i and stall_i together: flush wins.
REQ-026 Bubble on capture: when valid_i=0, captured ctrl_o SHALL be forced to 4'b0000 regardless of ctrl_i.
REQ-027 rd_addr_i=0: captured rd_wren bit SHALL be forced 0 (x0 never written).
REQ-028 hazard_o = valid_o & ctrl_o[3] & (rd_addr_o!=0) & (rd_addr_o==id_rs1_addr_i | rd_addr_o==id_rs2_addr_i).
REQ-029 bubble_cnt_o increments on each edge where a bubble is captured (flush_i=1, or stall_i=0 with valid_i=0).
REQ-030 stall_cnt_o increments on each edge with stall_i=1 and flush_i=0.
REQ-031 Counters saturate at all-ones; no wrap.

Reset
REQ-032 rst_ni low SHALL immediately (without clock) clear every output register and counter to 0; hazard_o thus 0.
REQ-033 Reset mid-stall or mid-flush: reset dominates; first post-reset edge behaves per REQ-022..025.

Configuration
REQ-034 Macro EX_MEM_PERF_CNT_EN: defined -> counters per REQ-029..031; undefined -> no counter flops, stall_cnt_o and bubble_cnt_o tied to 0, ports retained.

Verification
REQ-035 Reset: rst_ni low mid-cycle with valid_o=1 -> all outputs 0 before next edge.
REQ-036 Capture: valid_i=1, alu_data_i=32'hF800_0000, rd=5, ctrl=4'b1001 -> next cycle same values, valid_o=1.
REQ-037 Stall 3 cycles with changing inputs -> outputs frozen; stall_cnt_o=3 (macro on) / 0 (macro off).
REQ-038 flush_i=1 and stall_i=1 with valid_i=1 -> valid_o=0, ctrl_o=0, bubble_cnt_o +1, stall_cnt_o unchanged.
REQ-039 Hazard: registered rd=7, rd_wren=1, id_rs2=7 -> hazard_o=1; rd=0 with rd_wren_i=1 -> rd_wren forced 0, hazard_o=0.
REQ-040 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt_o=4'hF.
